// File: rtl/crossbar_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : crossbar_alloc
//  Description : Per-output round-robin allocator for a combinational
//                crossbar. Each output owns a two-state FSM that grants a
//                single input for a whole multi-beat packet and drives the
//                one-hot crossbar select row plus valid/ready flow control.
//  Revision    : 1.0 - initial release
// ============================================================================
module crossbar_alloc #(
  parameter int N  = 16,
  parameter int AW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_valid,
  input  logic [N*AW-1:0]   req_dest,
  input  logic [N-1:0]      req_last,
  output logic [N-1:0]      req_ready,
  input  logic [N-1:0]      out_ready,
  output logic [N-1:0]      out_valid,
  output logic [N*N-1:0]    sel
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  genvar gi, gj;

  for (gi = 0; gi < N; gi++) begin : g_out
    state_t          state_q, state_d;
    logic [AW-1:0]   owner_q, owner_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [AW-1:0]   pick;
    logic [N-1:0]    cand;
    logic [N-1:0]    row;
    logic            xfer;
    logic            is_last;

    // Candidate detection and the select row; a dest >= N never matches
    // because only indices below N are compared against it.
    for (gj = 0; gj < N; gj++) begin : g_in
      assign cand[gj] = req_valid[gj] && (req_dest[gj*AW +: AW] == AW'(gi));
      assign row[gj]  = (state_q == S_BUSY) && (owner_q == AW'(gj));
    end

    assign sel[gi*N +: N] = row;
    assign out_valid[gi]  = |(row & req_valid);
    assign xfer           = out_valid[gi] & out_ready[gi];
    assign is_last        = |(row & req_last);

    // Round-robin pick: lowest candidate at or above the pointer, otherwise
    // wrap around to the lowest candidate overall.
    always_comb begin
      pick = '0;
      for (int j = N - 1; j >= 0; j--) begin
        if (cand[j]) pick = AW'(j);
      end
      for (int j = N - 1; j >= 0; j--) begin
        if (cand[j] && (AW'(j) >= ptr_q)) pick = AW'(j);
      end
    end

    // Next-state logic: arbitrate in IDLE, hold the grant until the last
    // beat is accepted, then advance the pointer past the releasing owner.
    always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      case (state_q)
        S_IDLE: begin
          if (|cand) begin
            owner_d = pick;
            state_d = S_BUSY;
          end
        end
        S_BUSY: begin
          if (xfer && is_last) begin
            state_d = S_IDLE;
            ptr_d   = (owner_q == AW'(N - 1)) ? '0 : owner_q + AW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Per-output state registers; reset abandons any packet in flight.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= S_IDLE;
        owner_q <= '0;
        ptr_q   <= '0;
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
        ptr_q   <= ptr_d;
      end
    end
  end

  // An input is ready when the output it owns is ready; an input owns at
  // most one output, so OR-ing over all rows is unambiguous.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (sel[i*N + j] && out_ready[i]) req_ready[j] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_crossbar_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crossbar_alloc
//  Description : Self-checking bench for crossbar_alloc (N = 12). Per-cycle
//                vector table plus hand-written reset / mid-packet sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crossbar_alloc;
  localparam int N  = 12;
  localparam int AW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_dest;
  logic [N-1:0]      req_last;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      out_ready;
  logic [N-1:0]      out_valid;
  logic [N*N-1:0]    sel;

  int checks = 0;
  int errors = 0;

  crossbar_alloc #(.N(N), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_dest  (req_dest),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .sel       (sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]    rv;
    logic [N*AW-1:0] dest;
    logic [N-1:0]    last;
    logic [N-1:0]    ordy;
    logic [N*N-1:0]  e_sel;
    logic [N-1:0]    e_rr;
    logic [N-1:0]    e_ov;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [N-1:0] b(input int j);
    logic [N-1:0] r;
    r = '0;
    r[j] = 1'b1;
    return r;
  endfunction

  function automatic logic [N*N-1:0] grant(input int o, input int j);
    logic [N*N-1:0] r;
    r = '0;
    r[o*N + j] = 1'b1;
    return r;
  endfunction

  function automatic logic [N*AW-1:0] set_dest(input logic [N*AW-1:0] base,
                                               input int j, input int d);
    logic [N*AW-1:0] r;
    r = base;
    r[j*AW +: AW] = AW'(d);
    return r;
  endfunction

  task automatic add(input logic [N-1:0] rv, input logic [N*AW-1:0] dest,
                     input logic [N-1:0] last, input logic [N-1:0] ordy,
                     input logic [N*N-1:0] es, input logic [N-1:0] err,
                     input logic [N-1:0] eov);
    vec_t v;
    v.rv = rv; v.dest = dest; v.last = last; v.ordy = ordy;
    v.e_sel = es; v.e_rr = err; v.e_ov = eov;
    vecs.push_back(v);
  endtask

  task automatic check_outs(input string tag, input logic [N*N-1:0] es,
                            input logic [N-1:0] err, input logic [N-1:0] eov);
    checks++;
    if (sel !== es) begin
      errors++;
      $display("FAIL %s sel: got %h expected %h", tag, sel, es);
    end
    checks++;
    if (req_ready !== err) begin
      errors++;
      $display("FAIL %s req_ready: got %b expected %b", tag, req_ready, err);
    end
    checks++;
    if (out_valid !== eov) begin
      errors++;
      $display("FAIL %s out_valid: got %b expected %b", tag, out_valid, eov);
    end
  endtask

  initial begin
    logic [N-1:0]    all1, nr4, rv;
    logic [N*AW-1:0] d;
    logic [N*N-1:0]  s;
    int              order [5];

    all1 = '1;
    nr4  = all1 & ~b(4);

    // ---------------- vector table ----------------
    // Single flow: input 3 -> output 5, 4 beats, then one bubble.
    d = set_dest('0, 3, 5);
    add(b(3), d, '0, all1, '0, '0, '0);
    for (int k = 0; k < 3; k++) add(b(3), d, '0, all1, grant(5, 3), b(3), b(5));
    add(b(3), d, b(3), all1, grant(5, 3), b(3), b(5));
    add('0, d, '0, all1, '0, '0, '0);

    // Contention: inputs 0, 2, 7 single-beat packets to output 4.
    d = '0;
    d = set_dest(d, 0, 4);
    d = set_dest(d, 2, 4);
    d = set_dest(d, 7, 4);
    rv = b(0) | b(2) | b(7);
    order = '{0, 2, 7, 0, 2};
    add(rv, d, all1, all1, '0, '0, '0);
    for (int k = 0; k < 5; k++) begin
      add(rv, d, all1, all1, grant(4, order[k]), b(order[k]), b(4));
      if (k < 4) add(rv, d, all1, all1, '0, '0, '0);
      else       add('0, d, all1, all1, '0, '0, '0);
    end

    // Backpressure: input 1 -> output 4, 3 beats with stalls and a
    // mid-packet valid drop.
    d = set_dest('0, 1, 4);
    add(b(1), d, '0, all1, '0, '0, '0);
    add(b(1), d, '0, all1, grant(4, 1), b(1), b(4));
    add(b(1), d, '0, nr4,  grant(4, 1), '0,   b(4));
    add(b(1), d, '0, nr4,  grant(4, 1), '0,   b(4));
    add(b(1), d, '0, all1, grant(4, 1), b(1), b(4));
    add('0,   d, '0, all1, grant(4, 1), b(1), '0);
    add(b(1), d, b(1), nr4,  grant(4, 1), '0,   b(4));
    add(b(1), d, b(1), all1, grant(4, 1), b(1), b(4));
    add('0,   d, '0, all1, '0, '0, '0);

    // Permutation: input j -> output N-1-j for all j.
    d = '0;
    s = '0;
    for (int j = 0; j < N; j++) begin
      d = set_dest(d, j, N - 1 - j);
      s = s | grant(N - 1 - j, j);
    end
    add(all1, d, all1, all1, '0, '0, '0);
    add(all1, d, all1, all1, s, all1, all1);
    add('0, d, '0, all1, '0, '0, '0);

    // ---------------- reset sequence ----------------
    rst = 1'b1;
    req_valid = all1;
    req_dest  = '0;
    req_last  = '0;
    out_ready = all1;
    @(negedge clk);
    @(negedge clk);
    check_outs("reset_hold", '0, '0, '0);
    rst = 1'b0;
    #1;
    check_outs("reset_release", '0, '0, '0);
    @(negedge clk);
    #1;
    check_outs("first_grant", grant(0, 0), b(0), b(0));
    rst = 1'b1;
    #1;
    check_outs("reset_async", '0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;

    // ---------------- table run ----------------
    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      req_valid = vecs[k].rv;
      req_dest  = vecs[k].dest;
      req_last  = vecs[k].last;
      out_ready = vecs[k].ordy;
      #1;
      check_outs($sformatf("vec%0d", k), vecs[k].e_sel, vecs[k].e_rr, vecs[k].e_ov);
    end

    // ---------------- mid-packet reset ----------------
    @(negedge clk);
    req_valid = b(6);
    req_dest  = set_dest('0, 6, 2);
    req_last  = '0;
    out_ready = all1;
    #1;
    check_outs("mp_req", '0, '0, '0);
    @(negedge clk);
    #1;
    check_outs("mp_beat1", grant(2, 6), b(6), b(2));
    @(negedge clk);
    #1;
    check_outs("mp_beat2", grant(2, 6), b(6), b(2));
    #1;
    rst = 1'b1;
    #1;
    check_outs("mp_reset", '0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- invalid destination ----------------
    req_dest = set_dest('0, 6, 13);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check_outs($sformatf("bad_dest%0d", k), '0, '0, '0);
    end
    req_dest = set_dest('0, 6, 12);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      check_outs($sformatf("bad_dest12_%0d", k), '0, '0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/crossbar_alloc.md
# crossbar_alloc

Cycle-based allocator that drives the one-hot select bus of the combinational `crossbar` data path. It takes N independent requesters, each naming one destination port. It arbitrates each output round-robin and holds a grant for a whole multi-beat packet. It returns per-input ready and per-output valid flow control. It sits beside the crossbar: `sel` from this block feeds the crossbar `sel` input directly, and data never passes through this block.

## Interface

- N, 16, number of ports (inputs = outputs = N), N >= 2
- AW, $clog2(N), destination index width
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  N  input j has a beat pending
- req_dest  input  N*AW  destination of input j at bits [j*AW +: AW]; stable while req_valid[j]
- req_last  input  N  current beat of input j ends its packet
- req_ready  output  N  beat of input j is accepted this cycle
- out_ready  input  N  output i can accept a beat
- out_valid  output  N  output i carries a valid beat
- sel  output  N*N  row i at [i*N +: N] is one-hot of the input owning output i, or all-zero

## Operation

- Each output i has an independent FSM, a registered owner (AW bits) and a registered round-robin pointer ptr_i (AW bits).
- Candidates of output i: inputs j with req_valid[j]=1 and req_dest[j]==i. A dest value >= N is never a candidate for any output.
- IDLE:
  - sel row i = 0, out_valid[i] = 0.
  - If any candidate exists, pick the first candidate scanning j = ptr_i, ptr_i+1, ... modulo N.
  - Register it as owner and go to BUSY at the next edge.
  - No beat transfers in the arbitration cycle.
- BUSY:
  - sel row i = onehot(owner).
  - out_valid[i] = req_valid[owner].
  - req_ready[owner] = out_ready[i].
  - A beat transfers when out_valid[i] and out_ready[i] are both 1.
  - A transfer with req_last[owner]=1 returns the FSM to IDLE and sets ptr_i = (owner+1) mod N.
  - A transfer with req_last=0, or no transfer, stays in BUSY. req_valid may drop mid-packet; the grant is held.
- req_ready[j] = 0 whenever input j owns no output.
- An input can own at most one output, because its dest is stable.
- Different outputs are fully independent; any permutation may be active concurrently.
- A single-beat packet (req_last=1 on its first beat) is legal.
- After a packet ends, a new packet from the same input re-arbitrates and does not keep the output.

## Timing

- Reset values: every FSM in IDLE, owner=0, ptr=0. Therefore sel=0, out_valid=0, req_ready=0.
- Reset asserted mid-packet abandons the packet immediately (asynchronously) with no further handshakes.
- Grant latency: request seen in cycle t means sel row valid and first transfer possible in cycle t+1.
- Release: a last beat accepted in cycle t gives IDLE in t+1. The earliest next grant is in t+2, so there is a one-cycle bubble per packet.
- sel, out_valid and req_ready are combinational from FSM state, owner and req_valid/out_ready. There is no path from req_dest or req_last to sel within a cycle.
- Fairness: with K inputs continuously contending for one output, each is granted once per K packets.

## Test plan

- Reset: hold rst with all req_valid=1 -> sel=0, out_valid=0, req_ready=0. Release rst -> first grants appear one cycle later.
- Single flow:
  - Stimulus: input 3, dest 5, 4-beat packet, out_ready=1.
  - Expect: sel row 5 = 16'h0008 for exactly 4 cycles, starting one cycle after req_valid, with req_ready[3]=1 on each of those cycles.
  - Then row 5 = 0 for one cycle.
- Contention:
  - Stimulus: inputs 0, 2, 7 continuously send 1-beat packets to output 4.
  - Expect: grants in order 0, 2, 7, 0, 2, 7…, each followed by one idle cycle.
- Backpressure:
  - Stimulus: out_ready[4] toggles 1,0,0,1 during a 3-beat packet.
  - Expect: req_ready follows out_ready, the owner is unchanged, and the packet completes only after the third accepted beat.
- Permutation: input j → output (N-1-j) for all j simultaneously → all N sel rows active in the same cycle, each one-hot and distinct, with no interference.
- Mid-packet reset plus invalid dest:
  - Assert rst during beat 2 of a packet → sel clears immediately.
  - After release, with dest ≥ N (for N=12, dest=13) → the request is never granted and req_ready stays 0.
